// File: rtl/pipeline_sequencer_if.sv
// pipeline_sequencer_if
// ---------------------
// Bundles the control/bus signals exchanged between the core top level
// and the pipeline sequencer. The clock and reset are kept as plain
// module ports and are not part of this bundle.
//
// Signals (direction as seen from the sequencer, slave modport):
//   CONDITIONAL_JUMP  in   decode stage holds a branch/jump needing redirect
//   JUMP_DEST[31:0]   in   execute-stage branch target
//   MRET              in   decode stage holds mret
//   INTERRUPT         in   external interrupt request (level)
//   MTVEC_WE          in   write strobe for mtvec
//   MTVEC_WDATA[31:0] in   new mtvec value
//   PC[31:0]          out  fetch address (word index)
//   DECODER_ENABLED   out  decoder may accept the fetched instruction
//   CPU_MODE          out  0 = user, 1 = machine
//   MEPC[31:0]        out  saved return PC
//   MTVEC[31:0]       out  current trap vector
//   BUSY              out  sequencer is not in the RUN state
interface pipeline_sequencer_if;
    logic        CONDITIONAL_JUMP;
    logic [31:0] JUMP_DEST;
    logic        MRET;
    logic        INTERRUPT;
    logic        MTVEC_WE;
    logic [31:0] MTVEC_WDATA;
    logic [31:0] PC;
    logic        DECODER_ENABLED;
    logic        CPU_MODE;
    logic [31:0] MEPC;
    logic [31:0] MTVEC;
    logic        BUSY;

    // Core side: drives the requests, observes the sequencing state.
    modport master (
        output CONDITIONAL_JUMP, JUMP_DEST, MRET, INTERRUPT, MTVEC_WE, MTVEC_WDATA,
        input  PC, DECODER_ENABLED, CPU_MODE, MEPC, MTVEC, BUSY
    );

    // Sequencer side: consumes the requests, owns PC and trap CSRs.
    modport slave (
        input  CONDITIONAL_JUMP, JUMP_DEST, MRET, INTERRUPT, MTVEC_WE, MTVEC_WDATA,
        output PC, DECODER_ENABLED, CPU_MODE, MEPC, MTVEC, BUSY
    );
endinterface

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer
// ------------------
// Sequencing controller for the three-stage RV32I core. Owns the program
// counter, the decoder enable, the machine/user mode bit and the trap
// CSRs mepc/mtvec. Every cycle it decides whether fetch advances, holds,
// redirects to a branch target, enters the trap vector or returns via mret.
//
// Ports:
//   CLK    in  single clock, rising edge
//   RSTN   in  asynchronous active-low reset
//   bus    pipeline_sequencer_if.slave (requests in, PC/CSR/status out)
//
// Parameters:
//   RESET_PC     PC value after reset
//   MTVEC_RESET  reset value of mtvec
//
// Optional feature macro: PIPELINE_SEQUENCER_IRQ_PENDING_EN
//   When defined, an interrupt request that cannot be taken immediately is
//   remembered in a pending flag and taken at the first RUN cycle in user
//   mode. When undefined, such requests are simply lost.
module pipeline_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'd0,
    parameter logic [31:0] MTVEC_RESET = 32'd36
) (
    input logic                 CLK,
    input logic                 RSTN,
    pipeline_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        RUN,
        BR_EXEC,
        BR_WRITE,
        IRQ_D1,
        IRQ_D2,
        RET_D1,
        RET_D2
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic        decEn_q;
    logic        mode_q;
    logic [31:0] mepc_q;
    logic [31:0] mtvec_q;
    logic        busy_q;

    logic        irqReq;
    logic        higherEvent;
    logic        irqTake;

`ifdef PIPELINE_SEQUENCER_IRQ_PENDING_EN
    logic        pending_q;
    logic        pending_d;
`endif

    // Work out whether an interrupt is taken this cycle. A branch or an
    // mret in machine mode outranks the interrupt, and the interrupt is
    // never taken in machine mode (no nesting).
    always_comb begin
`ifdef PIPELINE_SEQUENCER_IRQ_PENDING_EN
        irqReq = bus.INTERRUPT | pending_q;
`else
        irqReq = bus.INTERRUPT;
`endif
        higherEvent = bus.CONDITIONAL_JUMP | (bus.MRET & mode_q);
        irqTake     = (state_q == RUN) & ~mode_q & ~higherEvent & irqReq;
    end

`ifdef PIPELINE_SEQUENCER_IRQ_PENDING_EN
    // Remember a request that could not be taken; taking the interrupt
    // always clears the flag, even if a new request arrives that cycle.
    always_comb begin
        pending_d = pending_q;
        if (irqTake) begin
            pending_d = 1'b0;
        end else if (bus.INTERRUPT) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end
`endif

    // Main sequencing FSM. All outputs are registered here alongside the
    // state; BUSY is loaded with the "next state is not RUN" value so it
    // always matches the state register.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            decEn_q <= 1'b1;
            mode_q  <= 1'b0;
            mepc_q  <= 32'd0;
            mtvec_q <= MTVEC_RESET;
            busy_q  <= 1'b0;
        end else begin
            // mtvec can be rewritten in any state; IRQ_D2 below still
            // reads the old registered value in the same cycle.
            if (bus.MTVEC_WE) begin
                mtvec_q <= bus.MTVEC_WDATA;
            end

            case (state_q)
                RUN: begin
                    if (bus.CONDITIONAL_JUMP) begin
                        decEn_q <= 1'b0;
                        state_q <= BR_EXEC;
                        busy_q  <= 1'b1;
                    end else if (bus.MRET && mode_q) begin
                        decEn_q <= 1'b0;
                        state_q <= RET_D1;
                        busy_q  <= 1'b1;
                    end else if (irqTake) begin
                        mepc_q  <= pc_q;
                        mode_q  <= 1'b1;
                        decEn_q <= 1'b0;
                        state_q <= IRQ_D1;
                        busy_q  <= 1'b1;
                    end else begin
                        pc_q <= pc_q + 32'd1;
                    end
                end

                // Load target-1 so the BR_WRITE increment lands on the
                // target; wraps to all-ones for a target of zero.
                BR_EXEC: begin
                    pc_q    <= bus.JUMP_DEST - 32'd1;
                    state_q <= BR_WRITE;
                end

                BR_WRITE: begin
                    pc_q    <= pc_q + 32'd1;
                    decEn_q <= 1'b1;
                    state_q <= RUN;
                    busy_q  <= 1'b0;
                end

                IRQ_D1: begin
                    state_q <= IRQ_D2;
                end

                IRQ_D2: begin
                    pc_q    <= mtvec_q;
                    decEn_q <= 1'b1;
                    state_q <= RUN;
                    busy_q  <= 1'b0;
                end

                RET_D1: begin
                    state_q <= RET_D2;
                end

                RET_D2: begin
                    pc_q    <= mepc_q;
                    mode_q  <= 1'b0;
                    decEn_q <= 1'b1;
                    state_q <= RUN;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= RUN;
                    decEn_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PC              = pc_q;
    assign bus.DECODER_ENABLED = decEn_q;
    assign bus.CPU_MODE        = mode_q;
    assign bus.MEPC            = mepc_q;
    assign bus.MTVEC           = mtvec_q;
    assign bus.BUSY            = busy_q;

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Sequencing controller for the three-stage RV32I core (fetch, decode/execute, write). It owns the program counter, the decoder enable, the machine/user mode bit and the trap CSRs `mepc`/`mtvec`. It replaces the ad-hoc stall and interrupt counters in the core top level with one FSM. It decides every cycle whether fetch advances, holds, redirects to a branch target, enters the trap vector, or returns via `mret`.

## Interface
Parameters:
- `RESET_PC`, default 32'd0: PC value after reset.
- `MTVEC_RESET`, default 32'd36: reset value of `mtvec` (trap handler entry).

Ports:
- `CLK`, input, 1: single clock, rising edge.
- `RSTN`, input, 1: asynchronous, active-low reset.
- `CONDITIONAL_JUMP`, input, 1: decode stage holds a branch/jump that needs a redirect.
- `JUMP_DEST`, input, 32: execute-stage branch target, valid in `BR_EXEC`.
- `MRET`, input, 1: decode stage holds `mret`.
- `INTERRUPT`, input, 1: external interrupt request, level.
- `MTVEC_WE`, input, 1: write strobe for `mtvec`.
- `MTVEC_WDATA`, input, 32: new `mtvec` value.
- `PC`, output, 32: fetch address, in word index units.
- `DECODER_ENABLED`, output, 1: decoder may accept the fetched instruction.
- `CPU_MODE`, output, 1: 0 = user, 1 = machine.
- `MEPC`, output, 32: saved return PC.
- `MTVEC`, output, 32: current trap vector.
- `BUSY`, output, 1: high in any state other than `RUN`.

## Operation
- States: `RUN`, `BR_EXEC`, `BR_WRITE`, `IRQ_D1`, `IRQ_D2`, `RET_D1`, `RET_D2`.
- Reset values: `PC`=`RESET_PC`, `DECODER_ENABLED`=1, `CPU_MODE`=0, `MEPC`=0, `MTVEC`=`MTVEC_RESET`, state `RUN`, pending flag 0.
- Priority in `RUN`, highest first:
  1. `CONDITIONAL_JUMP`: `DECODER_ENABLED`<=0, PC holds, go to `BR_EXEC`.
  2. `MRET` with `CPU_MODE`=1: `DECODER_ENABLED`<=0, PC holds, go to `RET_D1`.
  3. Interrupt taken with `CPU_MODE`=0: `MEPC`<=`PC`, `CPU_MODE`<=1, `DECODER_ENABLED`<=0, PC holds, go to `IRQ_D1`.
  4. Otherwise: `PC`<=`PC`+1.
- `BR_EXEC`: `PC`<=`JUMP_DEST`-1 (modulo 2^32, so 0 gives 32'hFFFF_FFFF), go to `BR_WRITE`.
- `BR_WRITE`: `PC`<=`PC`+1, `DECODER_ENABLED`<=1, go to `RUN`. Mode is unchanged, so branches inside the handler work.
- `IRQ_D1`: go to `IRQ_D2`, PC holds.
- `IRQ_D2`: `PC`<=`MTVEC` (registered value), `DECODER_ENABLED`<=1, go to `RUN`.
- `RET_D1`: go to `RET_D2`, PC holds.
- `RET_D2`: `PC`<=`MEPC`, `CPU_MODE`<=0, `DECODER_ENABLED`<=1, go to `RUN`.
- `MRET` while `CPU_MODE`=0 is ignored; it is treated as a normal instruction.
- `MTVEC_WE` updates `MTVEC` on the next edge in any state. If it coincides with `IRQ_D2`, PC takes the old `MTVEC` and the register takes the new value.
- `CONDITIONAL_JUMP`, `MRET` and `INTERRUPT` are ignored in every non-`RUN` state, except for the pending latch under the macro.
- Nested interrupts are not supported: the interrupt is never taken while `CPU_MODE`=1.

## Timing
- All state and outputs are registered. Outputs change only on a rising `CLK` or on asserted `RSTN`.
- Branch redirect: 3 cycles from `CONDITIONAL_JUMP` sampled to the PC running sequentially again. `DECODER_ENABLED` is low for exactly 2 cycles.
- Trap entry: 3 cycles from `INTERRUPT` sampled to `PC`=`MTVEC`. `DECODER_ENABLED` is low for 2 cycles.
- Trap return: same shape as entry; `PC`=`MEPC` 3 cycles after `MRET` is sampled.
- Reset mid-sequence (any state): all registers immediately take their reset values. No partial trap state survives; `MEPC` is cleared.
- `BUSY` = (state != `RUN`), registered together with the state.

## Configuration
- `PIPELINE_SEQUENCER_IRQ_PENDING_EN` defined:
  - A pending flag sets when `INTERRUPT`=1 and the interrupt is not taken that cycle (non-`RUN` state, machine mode, or a higher-priority event).
  - The interrupt condition in `RUN` is (`INTERRUPT` | pending). The flag clears when the interrupt is taken. Set and take in the same cycle leaves the flag clear.
- Not defined: no flag. `INTERRUPT` is sampled only in `RUN` with `CPU_MODE`=0; requests arriving at any other time are lost.

## Test plan
- Reset, free-run 5 cycles: PC=0,1,2,3,4,5; `DECODER_ENABLED`=1; `CPU_MODE`=0; `BUSY`=0.
- At PC=9 pulse `CONDITIONAL_JUMP`, with `JUMP_DEST`=12 in the next cycle: PC sequence 9,9,11,12,13; `DECODER_ENABLED` sequence 1,0,0,1.
- `INTERRUPT` at PC=7 with `MTVEC`=36: `MEPC`=7, `CPU_MODE`=1, PC becomes 36 after 3 cycles. Then `MRET` at PC=46: PC becomes 7 after 3 cycles, `CPU_MODE`=0.
- `INTERRUPT` and `CONDITIONAL_JUMP` together at PC=4: branch sequence runs first. Without the macro, an `INTERRUPT` pulse that drops before the branch sequence returns to `RUN` is lost. With the macro, the trap is taken in the first `RUN` cycle and `MEPC` is the post-branch PC.
- `MTVEC_WE`=1 with data 40 in the `IRQ_D2` cycle: PC=36, then `MTVEC`=40. The next trap vectors to 40.
- Assert `RSTN`=0 during `RET_D1`: immediately PC=0, `CPU_MODE`=0, `MEPC`=0, `DECODER_ENABLED`=1, `BUSY`=0.
